// File: rtl/microwave_controller.sv
// microwave_controller
//   Control core of a microwave oven. A 3-digit cook time (M:SS, BCD) is
//   entered from a one-hot keypad in IDLE and counted down at one tick per
//   CLK_HZ clock cycles while COOKING. The magnetron enable is high only
//   while COOKING.
//
//   Optional build macro: INPUT_SYNC_EN. When defined, every front-panel
//   input passes through a 2-flop synchronizer before use. This adds two
//   cycles of input-to-response latency.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high reset
//   keypad[9:0]  one-hot digit keys (bit n = digit n)
//   startn       start request, active-low, level-sensitive
//   stopn        stop/pause request, active-low, level-sensitive
//   clearn       clear request, active-low, level-sensitive
//   door_closed  1 = door closed
//   sec_ones     7-segment pattern, seconds units (bit0=a .. bit6=g)
//   sec_tens     7-segment pattern, seconds tens
//   mins         7-segment pattern, minutes
//   mag_on       magnetron enable, registered, 1 only in COOKING
module microwave_controller #(
    parameter int unsigned CLK_HZ = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [6:0] sec_ones,
    output logic [6:0] sec_tens,
    output logic [6:0] mins,
    output logic       mag_on
);

    localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {IDLE, COOKING, PAUSED} state_t;

    // Internal (possibly synchronized) views of the inputs
    logic [9:0] kp;
    logic       start_n, stop_n, clear_n, door;

`ifdef INPUT_SYNC_EN
    logic [9:0] kp_s1, kp_s2;
    logic [3:0] ctl_s1, ctl_s2;  // {startn, stopn, clearn, door_closed}

    always_ff @(posedge clock) begin
        if (reset) begin
            kp_s1  <= '0;
            kp_s2  <= '0;
            ctl_s1 <= 4'b1110;
            ctl_s2 <= 4'b1110;
        end else begin
            kp_s1  <= keypad;
            kp_s2  <= kp_s1;
            ctl_s1 <= {startn, stopn, clearn, door_closed};
            ctl_s2 <= ctl_s1;
        end
    end

    assign kp                            = kp_s2;
    assign {start_n, stop_n, clear_n, door} = ctl_s2;
`else
    assign kp      = keypad;
    assign start_n = startn;
    assign stop_n  = stopn;
    assign clear_n = clearn;
    assign door    = door_closed;
`endif

    state_t        state, state_nx;
    logic [3:0]    dig_m, dig_t, dig_u;
    logic [3:0]    dig_m_nx, dig_t_nx, dig_u_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [9:0]    kp_prev;

    logic       onehot;
    logic       press;
    logic [3:0] key_val;
    logic       time_zero;
    logic       start_ok;

    always_comb begin
        onehot  = 1'b0;
        key_val = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (kp == (10'd1 << i)) begin
                onehot  = 1'b1;
                key_val = 4'(i);
            end
        end
    end

    // A press is the transition from all-keys-released to a single key
    assign press     = onehot && (kp_prev == '0);
    assign time_zero = (dig_m == '0) && (dig_t == '0) && (dig_u == '0);
    assign start_ok  = !start_n && stop_n && clear_n && door && !time_zero;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            dig_m   <= '0;
            dig_t   <= '0;
            dig_u   <= '0;
            presc   <= '0;
            kp_prev <= '0;
            mag_on  <= 1'b0;
        end else begin
            state   <= state_nx;
            dig_m   <= dig_m_nx;
            dig_t   <= dig_t_nx;
            dig_u   <= dig_u_nx;
            presc   <= presc_nx;
            kp_prev <= kp;
            mag_on  <= (state_nx == COOKING);
        end
    end

    always_comb begin
        state_nx = state;
        dig_m_nx = dig_m;
        dig_t_nx = dig_t;
        dig_u_nx = dig_u;
        presc_nx = presc;

        if (!clear_n) begin
            state_nx = IDLE;
            dig_m_nx = '0;
            dig_t_nx = '0;
            dig_u_nx = '0;
            presc_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    presc_nx = '0;
                    if (press) begin
                        dig_m_nx = dig_t;
                        dig_t_nx = dig_u;
                        dig_u_nx = key_val;
                    end
                    if (start_ok) state_nx = COOKING;
                end
                COOKING: begin
                    if (!stop_n || !door) begin
                        state_nx = PAUSED;
                    end else if (presc == PRESC_MAX) begin
                        presc_nx = '0;
                        if (dig_u != '0) begin
                            dig_u_nx = dig_u - 4'd1;
                        end else if (dig_t != '0) begin
                            dig_t_nx = dig_t - 4'd1;
                            dig_u_nx = 4'd9;
                        end else begin
                            dig_m_nx = dig_m - 4'd1;
                            dig_t_nx = 4'd5;
                            dig_u_nx = 4'd9;
                        end
                        // Expiry: only 0:01 can decrement to 0:00
                        if (dig_m == '0 && dig_t == '0 && dig_u == 4'd1)
                            state_nx = IDLE;
                    end else begin
                        presc_nx = presc + 1'b1;
                    end
                end
                PAUSED: begin
                    if (start_ok) state_nx = COOKING;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign sec_ones = seg7(dig_u);
    assign sec_tens = seg7(dig_t);
    assign mins     = seg7(dig_m);

endmodule

// File: tb/tb_microwave_controller.sv
// Directed testbench for microwave_controller (default build, no input
// synchronizer). Uses a short tick period to keep runtime small.
module tb_microwave_controller;

    localparam int unsigned HZ = 10;

    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F,
                           S4 = 7'h66, S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07,
                           S8 = 7'h7F, S9 = 7'h6F;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] keypad;
    logic       startn, stopn, clearn, door_closed;
    logic [6:0] sec_ones, sec_tens, mins;
    logic       mag_on;

    int checks   = 0;
    int failures = 0;

    microwave_controller #(.CLK_HZ(HZ)) dut (
        .clock       (clock),
        .reset       (reset),
        .keypad      (keypad),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .mins        (mins),
        .mag_on      (mag_on)
    );

    always #5 clock = ~clock;

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input int d);
        keypad = 10'd1 << d;
        step(1);
        keypad = '0;
        step(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; keypad = '0; startn = 1'b1; stopn = 1'b1;
        clearn = 1'b1; door_closed = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        checks++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {S0, S0, S0, 1'b0}) begin
            failures++;
            $display("FAIL reset: got %h %h %h mag=%b, want 3f 3f 3f mag=0",
                     mins, sec_tens, sec_ones, mag_on);
        end
    endtask

    task automatic test_entry();
        press(1); press(4); press(0);
        checks++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {S1, S4, S0, 1'b0}) begin
            failures++;
            $display("FAIL entry_140: got %h %h %h mag=%b, want 06 66 3f mag=0",
                     mins, sec_tens, sec_ones, mag_on);
        end
    endtask

    task automatic test_countdown();
        door_closed = 1'b1; startn = 1'b0;
        step(1);
        startn = 1'b1;
        checks++;
        if (mag_on !== 1'b1) begin
            failures++;
            $display("FAIL start_mag: got %b, want 1", mag_on);
        end
        step(HZ - 1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S1, S4, S0}) begin
            failures++;
            $display("FAIL pre_tick: got %h %h %h, want 06 66 3f", mins, sec_tens, sec_ones);
        end
        step(1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S1, S3, S9}) begin
            failures++;
            $display("FAIL tick_139: got %h %h %h, want 06 4f 6f", mins, sec_tens, sec_ones);
        end
        step(39 * HZ);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S1, S0, S0}) begin
            failures++;
            $display("FAIL at_100: got %h %h %h, want 06 3f 3f", mins, sec_tens, sec_ones);
        end
        step(HZ);
        checks++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {S0, S5, S9, 1'b1}) begin
            failures++;
            $display("FAIL borrow_059: got %h %h %h mag=%b, want 3f 6d 6f mag=1",
                     mins, sec_tens, sec_ones, mag_on);
        end
    endtask

    task automatic test_stop_resume();
        stopn = 1'b0;
        step(1);
        checks++;
        if (mag_on !== 1'b0) begin
            failures++;
            $display("FAIL stop_mag: got %b, want 0", mag_on);
        end
        step(5 * HZ);
        checks++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {S0, S5, S9, 1'b0}) begin
            failures++;
            $display("FAIL frozen: got %h %h %h mag=%b, want 3f 6d 6f mag=0",
                     mins, sec_tens, sec_ones, mag_on);
        end
        startn = 1'b0;
        stopn  = 1'b1;
        step(1);
        startn = 1'b1;
        checks++;
        if (mag_on !== 1'b1) begin
            failures++;
            $display("FAIL resume_mag: got %b, want 1", mag_on);
        end
        step(HZ - 1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S0, S5, S9}) begin
            failures++;
            $display("FAIL resume_hold: got %h %h %h, want 3f 6d 6f", mins, sec_tens, sec_ones);
        end
        step(1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S0, S5, S8}) begin
            failures++;
            $display("FAIL resume_058: got %h %h %h, want 3f 6d 7f", mins, sec_tens, sec_ones);
        end
    endtask

    task automatic test_clear();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        checks++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {S0, S0, S0, 1'b0}) begin
            failures++;
            $display("FAIL clear_cook: got %h %h %h mag=%b, want 3f 3f 3f mag=0",
                     mins, sec_tens, sec_ones, mag_on);
        end
        startn = 1'b0;
        step(3);
        startn = 1'b1;
        checks++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {S0, S0, S0, 1'b0}) begin
            failures++;
            $display("FAIL start_zero: got %h %h %h mag=%b, want 3f 3f 3f mag=0",
                     mins, sec_tens, sec_ones, mag_on);
        end
        press(5);
        startn = 1'b0;
        step(1);
        startn = 1'b1;
        stopn  = 1'b0;
        step(1);
        checks++;
        if ({sec_ones, mag_on} !== {S5, 1'b0}) begin
            failures++;
            $display("FAIL paused_005: got ones=%h mag=%b, want 6d mag=0", sec_ones, mag_on);
        end
        clearn = 1'b0;
        stopn  = 1'b1;
        step(1);
        clearn = 1'b1;
        checks++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {S0, S0, S0, 1'b0}) begin
            failures++;
            $display("FAIL clear_paused: got %h %h %h mag=%b, want 3f 3f 3f mag=0",
                     mins, sec_tens, sec_ones, mag_on);
        end
    endtask

    task automatic test_door();
        press(2);
        startn = 1'b0;
        step(1);
        startn = 1'b1;
        step(HZ);
        checks++;
        if ({sec_ones, mag_on} !== {S1, 1'b1}) begin
            failures++;
            $display("FAIL door_001: got ones=%h mag=%b, want 06 mag=1", sec_ones, mag_on);
        end
        door_closed = 1'b0;
        step(1);
        step(3);
        checks++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {S0, S0, S1, 1'b0}) begin
            failures++;
            $display("FAIL door_open: got %h %h %h mag=%b, want 3f 3f 06 mag=0",
                     mins, sec_tens, sec_ones, mag_on);
        end
        door_closed = 1'b1;
        startn = 1'b0;
        step(1);
        startn = 1'b1;
        step(HZ - 1);
        checks++;
        if ({sec_ones, mag_on} !== {S1, 1'b1}) begin
            failures++;
            $display("FAIL door_resume: got ones=%h mag=%b, want 06 mag=1", sec_ones, mag_on);
        end
        step(1);
        checks++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {S0, S0, S0, 1'b0}) begin
            failures++;
            $display("FAIL expiry: got %h %h %h mag=%b, want 3f 3f 3f mag=0",
                     mins, sec_tens, sec_ones, mag_on);
        end
        // Level start must not restart at 0:00
        startn = 1'b0;
        step(2);
        startn = 1'b1;
        checks++;
        if (mag_on !== 1'b0) begin
            failures++;
            $display("FAIL expiry_restart: got %b, want 0", mag_on);
        end
    endtask

    task automatic test_keypad_edges();
        keypad = 10'b00_0000_0011;
        step(1);
        keypad = '0;
        step(1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S0, S0, S0}) begin
            failures++;
            $display("FAIL multi_bit: got %h %h %h, want 3f 3f 3f", mins, sec_tens, sec_ones);
        end
        keypad = 10'd1 << 7;
        step(50);
        keypad = '0;
        step(1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S0, S0, S7}) begin
            failures++;
            $display("FAIL held_key: got %h %h %h, want 3f 3f 07", mins, sec_tens, sec_ones);
        end
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        press(9); press(9);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S0, S9, S9}) begin
            failures++;
            $display("FAIL entry_099: got %h %h %h, want 3f 6f 6f", mins, sec_tens, sec_ones);
        end
        startn = 1'b0;
        step(1);
        startn = 1'b1;
        press(3);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S0, S9, S9}) begin
            failures++;
            $display("FAIL key_in_cook: got %h %h %h, want 3f 6f 6f", mins, sec_tens, sec_ones);
        end
        step(HZ - 2);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S0, S9, S8}) begin
            failures++;
            $display("FAIL tick_098: got %h %h %h, want 3f 6f 7f", mins, sec_tens, sec_ones);
        end
        step(HZ);
        checks++;
        if ({mins, sec_tens, sec_ones} !== {S0, S9, S7}) begin
            failures++;
            $display("FAIL tick_097: got %h %h %h, want 3f 6f 07", mins, sec_tens, sec_ones);
        end
    endtask

    task automatic test_reset_mid_cook();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {S0, S0, S0, 1'b0}) begin
            failures++;
            $display("FAIL reset_cook: got %h %h %h mag=%b, want 3f 3f 3f mag=0",
                     mins, sec_tens, sec_ones, mag_on);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_countdown();
        test_stop_resume();
        test_clear();
        test_door();
        test_keypad_edges();
        test_reset_mid_cook();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microwave_controller.md
Name: microwave_controller

Overview:
- Control core of a microwave oven.
- Accepts a 3-digit cook time (M:SS) from a one-hot decimal keypad and counts it down at 1 Hz, derived from the system clock.
- Drives the magnetron enable and three 7-segment digit displays.
- Sits between the front-panel input logic (keypad, start/stop/clear buttons, door switch) and the display/power stage.

Parameters:
- CLK_HZ, 100, clock cycles per one-second countdown tick (minimum 2).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- keypad  input  10  one-hot digit keys; bit n = digit n (bit0 = "0" … bit9 = "9").
- startn  input  1  start request, active-low, level-sensitive.
- stopn  input  1  stop/pause request, active-low, level-sensitive.
- clearn  input  1  clear request, active-low, level-sensitive.
- door_closed  input  1  1 = door closed.
- sec_ones  output  7  7-segment pattern, seconds units digit.
- sec_tens  output  7  7-segment pattern, seconds tens digit.
- mins  output  7  7-segment pattern, minutes digit.
- mag_on  output  1  magnetron enable; 1 only in COOKING.

Behaviour:
- Segment encoding:
  - Active-high, bit0=a, bit1=b, … bit6=g.
  - Digits 0–9 use standard patterns: 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Time register: three 4-bit BCD digits M, T, U. Reset value 0:00, so all displays read 7'h3F.
- States:
  - IDLE is the reset state.
  - COOKING, with mag_on=1.
  - PAUSED.
  - mag_on is registered: it is 1 exactly while state==COOKING and 0 on reset.
- Keypad entry (IDLE only):
  - A key press is the cycle when keypad goes from 0 to exactly one bit set.
  - On a press: M<=T, T<=U, U<=digit. The old M is discarded. The display updates on the next edge.
  - Patterns with more than one bit set are ignored, and a held key enters only once.
  - Keypad is ignored in COOKING and PAUSED.
  - T may hold 6–9 through entry; there is no normalization.
- Priority per cycle: reset > clear > stop > door open > start.
- clearn=0 (any state): time <= 0:00, state <= IDLE, prescaler <= 0.
- stopn=0 in COOKING: go to PAUSED; time and prescaler are held.
- door_closed=0 in COOKING: go to PAUSED.
- Start: startn=0 with stopn=1, clearn=1, door_closed=1 and time != 0:00, in IDLE or PAUSED → COOKING. Start with time 0:00 is ignored.
- Countdown:
  - In COOKING the prescaler counts 0..CLK_HZ-1. A tick occurs when it wraps.
  - Each tick decrements BCD:
    - U>0: U-1.
    - Else if T>0: T-1, U=9.
    - Else: M-1, T=5, U=9.
  - The prescaler holds in PAUSED and is zeroed on entry to IDLE.
- Expiry: the tick producing 0:00 moves the state to IDLE on the same edge; mag_on falls with it.
- Level semantics: startn held low keeps retrying. Releasing stopn while startn is still low resumes COOKING on the next edge.
- Reset mid-cook: state IDLE, time 0:00, mag_on 0 on the edge after reset is sampled.

Optional Feature:
- Macro INPUT_SYNC_EN.
- When defined: keypad, startn, stopn, clearn and door_closed each pass through a 2-flop synchronizer before use. This adds 2 cycles of input-to-response latency. The synchronizer flops reset to the inactive values (keypad=0, startn/stopn/clearn=1, door_closed=0).
- When undefined: inputs are used directly and are assumed synchronous to clock.

Test Plan:
- Reset, then press keys 1,4,0 (one press each, separated by keypad=0) → displays mins=06, sec_tens=66, sec_ones=3F (1:40); mag_on=0.
- From 1:40, door closed, startn=0 → mag_on=1 next edge. After CLK_HZ cycles the display reads 1:39. After 40 ticks it reads 1:00; the next tick gives 0:59.
- While cooking, stopn=0 for 5 s → mag_on=0 and the display frozen. Releasing stopn with startn still 0 resumes counting from the frozen value.
- clearn=0 while cooking or paused → 0:00, IDLE, mag_on=0. startn=0 at 0:00 → stays IDLE.
- Enter 0:02, start, open the door after 1 s → PAUSED at 0:01. Close the door with startn=0 → resumes; after 1 more second reaches 0:00, IDLE, mag_on=0.
- Keypad edge cases: two bits set → no change. Key held 50 cycles → single entry. Keys pressed during COOKING → ignored. Entering 9,9 → 0:99, which counts down 0:99, 0:98, …
